// File: rtl/knock_timer_ctrl_pkg.sv
// Shared state encoding and timing constants for the knock-operated countdown timer.
// All durations are in 1 kHz clock cycles.
package knock_timer_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle     = 2'd0,
        StArmed    = 2'd1,
        StRinging  = 2'd2,
        StCooldown = 2'd3
    } state_e;

    localparam int unsigned DEB_CYC   = 20;
    localparam int unsigned LOCK_CYC  = 200;
    localparam int unsigned BEEP_CYC  = 250;
    localparam int unsigned RING_CYC  = 10000;
    localparam int unsigned COOL_CYC  = 1000;
    localparam int unsigned MAX_KNOCK = 19;

endpackage

// File: rtl/knock_debounce.sv
// Synchronises and debounces the raw knock sensor, then applies a post-accept lockout.
// accept_o is a one-cycle pulse per qualified knock that falls outside the lockout window.
module knock_debounce
    import knock_timer_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic knock_raw_i,
    output logic accept_o
);

    logic [1:0] sync_q;
    logic [4:0] deb_cnt_q, deb_cnt_d;
    logic       pressed_q, pressed_d;
    logic [7:0] lock_q, lock_d;
    logic       detect;
    logic       knock_low;

    assign knock_low = ~sync_q[1];

    always_comb begin
        deb_cnt_d = deb_cnt_q;
        pressed_d = pressed_q;
        detect    = 1'b0;
        // Counter tracks low cycles while released, high cycles while pressed.
        if (!pressed_q) begin
            if (!knock_low) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == 5'(DEB_CYC - 1)) begin
                detect    = 1'b1;
                pressed_d = 1'b1;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 5'd1;
            end
        end else begin
            if (knock_low) begin
                deb_cnt_d = '0;
            end else if (deb_cnt_q == 5'(DEB_CYC - 1)) begin
                pressed_d = 1'b0;
                deb_cnt_d = '0;
            end else begin
                deb_cnt_d = deb_cnt_q + 5'd1;
            end
        end

        accept_o = detect && (lock_q == '0);
        if (accept_o) begin
            lock_d = 8'(LOCK_CYC);
        end else if (lock_q != '0) begin
            lock_d = lock_q - 8'd1;
        end else begin
            lock_d = lock_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= 2'b11;
            deb_cnt_q <= '0;
            pressed_q <= 1'b0;
            lock_q    <= '0;
        end else begin
            sync_q    <= {sync_q[0], knock_raw_i};
            deb_cnt_q <= deb_cnt_d;
            pressed_q <= pressed_d;
            lock_q    <= lock_d;
        end
    end

endmodule

// File: rtl/knock_timer_ctrl.sv
// Knock-operated countdown timer controller: arms on a knock, forwards knocks to the timer,
// rings on expiry with a 250/250 beep pattern, then cools down before accepting knocks again.
module knock_timer_ctrl
    import knock_timer_ctrl_pkg::*;
(
    input  logic       CLK1K,
    input  logic       RSTN,
    input  logic       KNOCK_RAW,
    input  logic       CANCEL,
    input  logic       ALARM,
    output logic       KNOCK,
    output logic       TMR_CLR_N,
    output logic       BUZZ,
    output logic [1:0] STATE
);

    logic accept;

    knock_debounce u_debounce (
        .clk_i       (CLK1K),
        .rst_ni      (RSTN),
        .knock_raw_i (KNOCK_RAW),
        .accept_o    (accept)
    );

    state_e      state_q, state_d;
    logic [4:0]  fwd_cnt_q, fwd_cnt_d;
    logic [13:0] timer_q, timer_d;
    logic [7:0]  beep_q, beep_d;
    logic        phase_q, phase_d;
    logic        knock_n_q, knock_n_d;
    logic        hold_q, hold_d;
    logic        clr_n_q, clr_n_d;
    logic        fwd;

    always_comb begin
        state_d = state_q;
        fwd     = 1'b0;
        clr_n_d = 1'b1;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StArmed;
                    fwd     = 1'b1;
                end
            end
            StArmed: begin
                // Cancel wins over alarm, alarm over knock; losers are dropped.
                if (CANCEL) begin
                    clr_n_d = 1'b0;
                    state_d = StIdle;
                end else if (ALARM) begin
                    state_d = StRinging;
                end else if (accept && (fwd_cnt_q < 5'(MAX_KNOCK))) begin
                    fwd = 1'b1;
                end
            end
            StRinging: begin
                if (CANCEL || accept || (timer_q == 14'(RING_CYC - 1))) begin
                    state_d = StCooldown;
                end
            end
            StCooldown: begin
                if (timer_q == 14'(COOL_CYC - 1)) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        if ((state_d == StIdle) && (state_q != StIdle)) begin
            fwd_cnt_d = '0;
        end else if (fwd) begin
            fwd_cnt_d = fwd_cnt_q + 5'd1;
        end else begin
            fwd_cnt_d = fwd_cnt_q;
        end

        if ((state_d != state_q) || ((state_q != StRinging) && (state_q != StCooldown))) begin
            timer_d = '0;
        end else begin
            timer_d = timer_q + 14'd1;
        end

        // Beep phase is held at zero outside ringing so the first ringing cycle sounds.
        beep_d  = '0;
        phase_d = 1'b0;
        if (state_q == StRinging) begin
            if (beep_q == 8'(BEEP_CYC - 1)) begin
                phase_d = ~phase_q;
            end else begin
                beep_d  = beep_q + 8'd1;
                phase_d = phase_q;
            end
        end

        knock_n_d = ~(fwd | hold_q);
        hold_d    = fwd;
    end

    always_ff @(posedge CLK1K or negedge RSTN) begin
        if (!RSTN) begin
            state_q   <= StIdle;
            fwd_cnt_q <= '0;
            timer_q   <= '0;
            beep_q    <= '0;
            phase_q   <= 1'b0;
            knock_n_q <= 1'b1;
            hold_q    <= 1'b0;
            clr_n_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            fwd_cnt_q <= fwd_cnt_d;
            timer_q   <= timer_d;
            beep_q    <= beep_d;
            phase_q   <= phase_d;
            knock_n_q <= knock_n_d;
            hold_q    <= hold_d;
            clr_n_q   <= clr_n_d;
        end
    end

    assign KNOCK     = knock_n_q;
    assign TMR_CLR_N = clr_n_q;
    assign BUZZ      = (state_q == StRinging) && !phase_q;
    assign STATE     = state_q;

endmodule

// File: tb/tb_knock_timer_ctrl.sv
// Self-checking bench for knock_timer_ctrl: scenario tasks with randomized knock timing,
// expected outcomes computed from press lengths, gaps and the debounce/lockout/limit rules.
module tb_knock_timer_ctrl;

    logic       CLK1K = 1'b0;
    logic       RSTN = 1'b0;
    logic       KNOCK_RAW = 1'b1;
    logic       CANCEL = 1'b0;
    logic       ALARM = 1'b0;
    logic       KNOCK;
    logic       TMR_CLR_N;
    logic       BUZZ;
    logic [1:0] STATE;

    int total = 0;
    int bad = 0;

    // Monotonic output monitors, sampled mid-cycle.
    int   neg_n = 0;
    int   kfall = 0;
    int   klow = 0;
    int   clr_low = 0;
    int   buzz_hi = 0;
    int   last_fall_n = 0;
    logic knock_prev = 1'b1;

    knock_timer_ctrl dut (
        .CLK1K     (CLK1K),
        .RSTN      (RSTN),
        .KNOCK_RAW (KNOCK_RAW),
        .CANCEL    (CANCEL),
        .ALARM     (ALARM),
        .KNOCK     (KNOCK),
        .TMR_CLR_N (TMR_CLR_N),
        .BUZZ      (BUZZ),
        .STATE     (STATE)
    );

    always #5 CLK1K = ~CLK1K;

    always @(negedge CLK1K) begin
        neg_n <= neg_n + 1;
        if (KNOCK === 1'b0) begin
            klow <= klow + 1;
            if (knock_prev === 1'b1) begin
                kfall       <= kfall + 1;
                last_fall_n <= neg_n + 1;
            end
        end
        knock_prev <= KNOCK;
        if (TMR_CLR_N === 1'b0) clr_low <= clr_low + 1;
        if (BUZZ === 1'b1) buzz_hi <= buzz_hi + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK1K);
        #1;
    endtask

    task automatic do_reset();
        RSTN = 1'b0;
        KNOCK_RAW = 1'b1;
        CANCEL = 1'b0;
        ALARM = 1'b0;
        tick(3);
        RSTN = 1'b1;
        tick(3);
    endtask

    task automatic press(input int low_cyc, input int high_cyc);
        KNOCK_RAW = 1'b0;
        tick(low_cyc);
        KNOCK_RAW = 1'b1;
        tick(high_cyc);
    endtask

    task automatic pulse_alarm();
        ALARM = 1'b1;
        tick(1);
        ALARM = 1'b0;
    endtask

    task automatic test_reset();
        RSTN = 1'b0;
        tick(2);
        #2;
        total += 4;
        if (KNOCK !== 1'b1) begin bad++; $display("FAIL reset_knock: got %b want 1", KNOCK); end
        if (TMR_CLR_N !== 1'b1) begin bad++; $display("FAIL reset_clr: got %b want 1", TMR_CLR_N); end
        if (BUZZ !== 1'b0) begin bad++; $display("FAIL reset_buzz: got %b want 0", BUZZ); end
        if (STATE !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", STATE); end
        tick(1);
        RSTN = 1'b1;
        tick(3);
    endtask

    task automatic test_short_press();
        int b;
        do_reset();
        b = kfall;
        press(15, 40);
        press(19, 40);
        total += 3;
        if (kfall - b !== 0) begin bad++; $display("FAIL short_pulses: got %0d want 0", kfall - b); end
        if (STATE !== 2'd0) begin bad++; $display("FAIL short_state: got %0d want 0", STATE); end
        if (KNOCK !== 1'b1) begin bad++; $display("FAIL short_knock: got %b want 1", KNOCK); end
    endtask

    task automatic test_accept();
        int b, bl, n0;
        do_reset();
        b = kfall;
        bl = klow;
        n0 = neg_n;
        press(30, 70);
        total += 4;
        if (kfall - b !== 1) begin bad++; $display("FAIL accept_pulses: got %0d want 1", kfall - b); end
        if (klow - bl !== 2) begin bad++; $display("FAIL accept_width: got %0d want 2", klow - bl); end
        // 2 sync + 20 debounce cycles, pulse starts the cycle after acceptance.
        if (last_fall_n - n0 !== 23) begin
            bad++; $display("FAIL accept_latency: got %0d want 23", last_fall_n - n0);
        end
        if (STATE !== 2'd1) begin bad++; $display("FAIL accept_state: got %0d want 1", STATE); end
        press(30, 50);
        total += 1;
        if (kfall - b !== 1) begin bad++; $display("FAIL lockout_drop: got %0d want 1", kfall - b); end
    endtask

    task automatic test_lockout_random(input int round);
        int lens[12];
        int gaps[12];
        int t, det, last_acc, exp_n, b;
        bit have_acc;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            lens[i] = int'($urandom_range(40, 5));
            gaps[i] = int'($urandom_range(250, 20));
        end
        lens[0] = 19;
        lens[1] = 20;
        t = 0;
        exp_n = 0;
        have_acc = 0;
        last_acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (lens[i] >= 20) begin
                det = t + 19;
                if (!have_acc || (det - last_acc > 200)) begin
                    exp_n++;
                    have_acc = 1;
                    last_acc = det;
                end
            end
            t += lens[i] + gaps[i];
        end
        b = kfall;
        for (int i = 0; i < 12; i++) press(lens[i], gaps[i]);
        total += 2;
        if (kfall - b !== exp_n) begin
            bad++; $display("FAIL rand_pulses[%0d]: got %0d want %0d", round, kfall - b, exp_n);
        end
        if (STATE !== ((exp_n > 0) ? 2'd1 : 2'd0)) begin
            bad++; $display("FAIL rand_state[%0d]: got %0d want %0d", round, STATE, (exp_n > 0));
        end
    endtask

    task automatic test_max_knocks();
        int b, bl;
        do_reset();
        b = kfall;
        bl = klow;
        for (int i = 0; i < 25; i++) press(int'($urandom_range(40, 20)), int'($urandom_range(220, 190)));
        total += 3;
        if (kfall - b !== 19) begin bad++; $display("FAIL max_pulses: got %0d want 19", kfall - b); end
        if (klow - bl !== 38) begin bad++; $display("FAIL max_lowcyc: got %0d want 38", klow - bl); end
        if (STATE !== 2'd1) begin bad++; $display("FAIL max_state: got %0d want 1", STATE); end
    endtask

    task automatic test_ring();
        int buzz_err, st_err, bk, bb;
        logic exp_buzz;
        logic [1:0] exp_st;
        do_reset();
        press(25, 30);
        bk = kfall;
        bb = buzz_hi;
        buzz_err = 0;
        st_err = 0;
        pulse_alarm();
        for (int k = 0; k <= 11000; k++) begin
            @(negedge CLK1K);
            exp_buzz = (k < 10000) && ((k / 250) % 2 == 0);
            exp_st = (k < 10000) ? 2'd2 : ((k < 11000) ? 2'd3 : 2'd0);
            if (BUZZ !== exp_buzz) begin
                if (buzz_err == 0) $display("first buzz deviation at ring cycle %0d", k);
                buzz_err++;
            end
            if (STATE !== exp_st) begin
                if (st_err == 0) $display("first state deviation at ring cycle %0d", k);
                st_err++;
            end
        end
        tick(1);
        total += 4;
        if (buzz_err !== 0) begin bad++; $display("FAIL ring_buzz: got %0d bad cycles want 0", buzz_err); end
        if (st_err !== 0) begin bad++; $display("FAIL ring_state: got %0d bad cycles want 0", st_err); end
        if (buzz_hi - bb !== 5000) begin
            bad++; $display("FAIL ring_buzz_total: got %0d want 5000", buzz_hi - bb);
        end
        if (kfall - bk !== 0) begin bad++; $display("FAIL ring_fwd: got %0d want 0", kfall - bk); end
    endtask

    task automatic test_ring_knock_end();
        int b;
        do_reset();
        press(25, 30);
        pulse_alarm();
        tick(int'($urandom_range(600, 300)));
        total += 1;
        if (STATE !== 2'd2) begin bad++; $display("FAIL knockend_pre: got %0d want 2", STATE); end
        b = kfall;
        press(25, 5);
        pulse_alarm();
        tick(2);
        total += 3;
        if (STATE !== 2'd3) begin bad++; $display("FAIL knockend_state: got %0d want 3", STATE); end
        if (kfall - b !== 0) begin bad++; $display("FAIL knockend_fwd: got %0d want 0", kfall - b); end
        if (BUZZ !== 1'b0) begin bad++; $display("FAIL knockend_buzz: got %b want 0", BUZZ); end
    endtask

    task automatic test_cancel_alarm();
        int bc, bb;
        do_reset();
        press(25, 30);
        bc = clr_low;
        bb = buzz_hi;
        CANCEL = 1'b1;
        ALARM = 1'b1;
        tick(1);
        CANCEL = 1'b0;
        ALARM = 1'b0;
        tick(10);
        total += 3;
        if (clr_low - bc !== 1) begin bad++; $display("FAIL cancel_clr: got %0d want 1", clr_low - bc); end
        if (STATE !== 2'd0) begin bad++; $display("FAIL cancel_state: got %0d want 0", STATE); end
        if (buzz_hi - bb !== 0) begin bad++; $display("FAIL cancel_buzz: got %0d want 0", buzz_hi - bb); end
    endtask

    task automatic test_reset_mid_ring();
        int bk, bc;
        do_reset();
        press(25, 30);
        pulse_alarm();
        tick(100);
        total += 1;
        if (BUZZ !== 1'b1) begin bad++; $display("FAIL midring_pre: got %b want 1", BUZZ); end
        RSTN = 1'b0;
        #1;
        total += 2;
        if (BUZZ !== 1'b0) begin bad++; $display("FAIL midring_buzz: got %b want 0", BUZZ); end
        if (STATE !== 2'd0) begin bad++; $display("FAIL midring_state: got %0d want 0", STATE); end
        tick(2);
        RSTN = 1'b1;
        bk = kfall;
        bc = clr_low;
        tick(50);
        total += 3;
        if (kfall - bk !== 0) begin bad++; $display("FAIL midring_knock: got %0d want 0", kfall - bk); end
        if (clr_low - bc !== 0) begin bad++; $display("FAIL midring_clr: got %0d want 0", clr_low - bc); end
        if (STATE !== 2'd0) begin bad++; $display("FAIL midring_after: got %0d want 0", STATE); end
    endtask

    task automatic test_reset_qual();
        int b, n0;
        RSTN = 1'b0;
        KNOCK_RAW = 1'b0;
        tick(3);
        b = kfall;
        n0 = neg_n;
        RSTN = 1'b1;
        tick(40);
        total += 2;
        if (kfall - b !== 1) begin bad++; $display("FAIL rstqual_pulses: got %0d want 1", kfall - b); end
        if (last_fall_n - n0 !== 23) begin
            bad++; $display("FAIL rstqual_latency: got %0d want 23", last_fall_n - n0);
        end
        KNOCK_RAW = 1'b1;
        tick(30);
    endtask

    initial begin
        test_reset();
        test_short_press();
        test_accept();
        for (int r = 0; r < 3; r++) test_lockout_random(r);
        test_max_knocks();
        test_ring();
        test_ring_knock_end();
        test_cancel_alarm();
        test_reset_mid_ring();
        test_reset_qual();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/knock_timer_ctrl.md
KNOCK_TIMER_CTRL -- requirements
Module: knock_timer_ctrl

Interface
REQ-001 SHALL have port CLK1K  input  1  1 kHz system clock; all state updates on its rising edge.
REQ-002 SHALL have port RSTN  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have port KNOCK_RAW  input  1  raw knock sensor; active-low, asynchronous, bouncy.
REQ-004 SHALL have port CANCEL  input  1  user cancel button; active-high, pre-synchronised level.
REQ-005 SHALL have port ALARM  input  1  one-cycle expiry pulse from the countdown timer.
REQ-006 SHALL have port KNOCK  output  1  clean knock to the timer; idle high, low for exactly 2 cycles per accepted knock.
REQ-007 SHALL have port TMR_CLR_N  output  1  timer clear; idle high, low for exactly 1 cycle.
REQ-008 SHALL have port BUZZ  output  1  buzzer drive; high = sound.
REQ-009 SHALL have port STATE  output  2  current FSM state: 0 IDLE, 1 ARMED, 2 RINGING, 3 COOLDOWN.

Function
REQ-010 SHALL synchronise KNOCK_RAW through 2 flops before any use.
REQ-011 SHALL accept a knock only after the synchronised input is low for 20 consecutive cycles, then re-arm only after 20 consecutive high cycles (5-bit counter).
REQ-012 SHALL enforce a 200-cycle lockout after each accepted knock; knocks detected during lockout are discarded (8-bit counter).
REQ-013 SHALL begin the 2-cycle KNOCK low pulse on the cycle after acceptance.
REQ-014 SHALL count forwarded knocks per run (5-bit) and stop forwarding at 19; the count clears on entry to IDLE.
REQ-015 IDLE: SHALL go to ARMED on an accepted knock, which is forwarded.
REQ-016 ARMED: SHALL forward accepted knocks; on ALARM go to RINGING; on CANCEL pulse TMR_CLR_N and go to IDLE.
REQ-017 ARMED priority SHALL be CANCEL > ALARM > knock; a lower-priority event in the same cycle is discarded.
REQ-018 RINGING: SHALL drive BUZZ high for 250 cycles, then low for 250 cycles, starting high on the first RINGING cycle.
REQ-019 RINGING SHALL end after 10000 cycles (14-bit counter), or on CANCEL or an accepted knock, whichever comes first; the terminating knock is not forwarded; next state COOLDOWN.
REQ-020 COOLDOWN: BUZZ SHALL be low; all knocks are discarded for 1000 cycles, then the state goes to IDLE.
REQ-021 SHALL ignore ALARM in IDLE, RINGING and COOLDOWN.
REQ-022 KNOCK and TMR_CLR_N SHALL be registered outputs with no combinational path from any input.

Reset
REQ-023 On RSTN low, SHALL immediately force: STATE=IDLE, KNOCK=1, TMR_CLR_N=1, BUZZ=0, and all counters and synchroniser flops to idle values (synchroniser flops = 1).
REQ-024 Reset mid-pulse or mid-ring SHALL truncate the activity with no further output pulse after release.
REQ-025 Debounce SHALL require a full 20-cycle qualification after reset release.

Structure
REQ-026 A shared package SHALL hold:
- the state encoding
- the constants DEB_CYC=20, LOCK_CYC=200, BEEP_CYC=250, RING_CYC=10000, COOL_CYC=1000, MAX_KNOCK=19
REQ-027 Debounce and lockout SHALL be a sub-module knock_debounce with outputs: one-cycle accept pulse.
REQ-028 The FSM, pulse generation and buzzer logic SHALL reside in knock_timer_ctrl.

Verification
REQ-029 KNOCK_RAW low for 15 cycles, then high -> no acceptance, KNOCK stays 1, STATE=0.
REQ-030 KNOCK_RAW low for 30 cycles in IDLE -> KNOCK low for 2 cycles, STATE=1; a second press 100 cycles later -> discarded.
REQ-031 25 valid spaced knocks in ARMED -> exactly 19 KNOCK pulses forwarded.
REQ-032 ALARM pulse in ARMED -> STATE=2; BUZZ high for cycles 0-249 and low for 250-499; after 10000 cycles STATE=3; after 1000 more STATE=0.
REQ-033 CANCEL and ALARM in the same ARMED cycle -> one TMR_CLR_N low cycle, STATE=0, BUZZ stays 0.
REQ-034 RSTN asserted during RINGING with BUZZ=1 -> BUZZ=0 and STATE=0 immediately; after release, no KNOCK or TMR_CLR_N pulse.
